// File: rtl/eth_tx_framer.sv
`default_nettype none
// =============================================================================
// Module   : eth_tx_framer
// Brief    : GMII-side TX framer: preamble/SFD, payload, zero pad, optional
//            FCS (compiled in with ETH_TX_FCS_EN), then inter-frame gap.
// Revision : 1.0
// =============================================================================
module eth_tx_framer #(
    parameter int unsigned IFG_CYCLES  = 12,
    parameter int unsigned MIN_PAYLOAD = 60
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic [8:0] fifo_rdd_i,
    input  logic       fifo_empty_i,
    output logic       fifo_pop_o,
    output logic [7:0] txd_o,
    output logic       tx_en_o,
    output logic       tx_er_o,
    output logic       busy_o,
    output logic       frame_done_o,
    output logic       underrun_o
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PRE  = 3'd1,
        S_SFD  = 3'd2,
        S_DATA = 3'd3,
        S_PAD  = 3'd4,
        S_FCS  = 3'd5,
        S_DROP = 3'd6,
        S_IFG  = 3'd7
    } state_t;

    localparam logic [7:0]  c_pre_last    = 8'd6;
    localparam logic [7:0]  c_ifg_last    = 8'(IFG_CYCLES - 1);
    localparam logic [15:0] c_min_payload = 16'(MIN_PAYLOAD);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [15:0] bcnt_q, bcnt_d;
    logic [7:0]  txd_q, txd_d;
    logic        tx_en_q, tx_en_d;
    logic        tx_er_q, tx_er_d;
    logic        ur_q, ur_d;
    logic        done_pend_q, done_pend_d;
    logic        done_q;

    logic [15:0] w_bcnt_inc;
    logic        w_pop;
    logic        w_payload_end;

`ifdef ETH_TX_FCS_EN
    localparam logic [7:0] c_fcs_last = 8'd3;

    logic [31:0] crc_q, crc_d;

    // Reflected CRC-32, one byte per call, LSB of the byte first.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] d);
        logic [31:0] c;
        c = crc ^ {24'h000000, d};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return c;
    endfunction
`endif

    assign w_bcnt_inc = (bcnt_q == 16'hFFFF) ? bcnt_q : bcnt_q + 16'd1;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        bcnt_d        = bcnt_q;
        txd_d         = 8'h00;
        tx_en_d       = 1'b0;
        tx_er_d       = 1'b0;
        ur_d          = 1'b0;
        done_pend_d   = 1'b0;
        w_pop         = 1'b0;
        w_payload_end = 1'b0;
`ifdef ETH_TX_FCS_EN
        crc_d         = crc_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (!fifo_empty_i) begin
                    state_d = S_PRE;
                    cnt_d   = 8'd0;
                end
            end

            S_PRE: begin
                txd_d   = 8'h55;
                tx_en_d = 1'b1;
                cnt_d   = cnt_q + 8'd1;
                if (cnt_q == c_pre_last) begin
                    state_d = S_SFD;
                    cnt_d   = 8'd0;
                end
            end

            S_SFD: begin
                txd_d   = 8'hD5;
                tx_en_d = 1'b1;
                bcnt_d  = 16'd0;
                state_d = S_DATA;
`ifdef ETH_TX_FCS_EN
                crc_d   = 32'hFFFFFFFF;
`endif
            end

            S_DATA: begin
                tx_en_d = 1'b1;
                if (fifo_empty_i) begin
                    // Underrun: one poisoned byte, then discard the rest of the frame.
                    tx_er_d = 1'b1;
                    ur_d    = 1'b1;
                    state_d = S_DROP;
                end else begin
                    w_pop  = 1'b1;
                    txd_d  = fifo_rdd_i[7:0];
                    bcnt_d = w_bcnt_inc;
`ifdef ETH_TX_FCS_EN
                    crc_d  = crc32_byte(crc_q, fifo_rdd_i[7:0]);
`endif
                    if (fifo_rdd_i[8]) begin
                        if (w_bcnt_inc < c_min_payload) begin
                            state_d = S_PAD;
                        end else begin
                            w_payload_end = 1'b1;
                        end
                    end
                end
            end

            S_PAD: begin
                tx_en_d = 1'b1;
                bcnt_d  = w_bcnt_inc;
`ifdef ETH_TX_FCS_EN
                crc_d   = crc32_byte(crc_q, 8'h00);
`endif
                if (w_bcnt_inc >= c_min_payload) begin
                    w_payload_end = 1'b1;
                end
            end

`ifdef ETH_TX_FCS_EN
            S_FCS: begin
                tx_en_d = 1'b1;
                cnt_d   = cnt_q + 8'd1;
                case (cnt_q[1:0])
                    2'd0:    txd_d = ~crc_q[7:0];
                    2'd1:    txd_d = ~crc_q[15:8];
                    2'd2:    txd_d = ~crc_q[23:16];
                    default: txd_d = ~crc_q[31:24];
                endcase
                if (cnt_q == c_fcs_last) begin
                    state_d     = S_IFG;
                    cnt_d       = 8'd0;
                    done_pend_d = 1'b1;
                end
            end
`endif

            S_DROP: begin
                if (!fifo_empty_i) begin
                    w_pop = 1'b1;
                    if (fifo_rdd_i[8]) begin
                        state_d = S_IFG;
                        cnt_d   = 8'd0;
                    end
                end
            end

            S_IFG: begin
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == c_ifg_last) begin
                    state_d = S_IDLE;
                    cnt_d   = 8'd0;
                end
            end

            default: begin
                state_d = S_IDLE;
                cnt_d   = 8'd0;
            end
        endcase

        if (w_payload_end) begin
            cnt_d = 8'd0;
`ifdef ETH_TX_FCS_EN
            state_d = S_FCS;
`else
            state_d     = S_IFG;
            done_pend_d = 1'b1;
`endif
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q     <= S_IDLE;
            cnt_q       <= 8'd0;
            bcnt_q      <= 16'd0;
            txd_q       <= 8'h00;
            tx_en_q     <= 1'b0;
            tx_er_q     <= 1'b0;
            ur_q        <= 1'b0;
            done_pend_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bcnt_q      <= bcnt_d;
            txd_q       <= txd_d;
            tx_en_q     <= tx_en_d;
            tx_er_q     <= tx_er_d;
            ur_q        <= ur_d;
            done_pend_q <= done_pend_d;
            // Delayed one cycle so the pulse lands just after the final byte.
            done_q      <= done_pend_q;
        end
    end

`ifdef ETH_TX_FCS_EN
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            crc_q <= 32'hFFFFFFFF;
        end else begin
            crc_q <= crc_d;
        end
    end
`endif

    assign fifo_pop_o   = w_pop;
    assign txd_o        = txd_q;
    assign tx_en_o      = tx_en_q;
    assign tx_er_o      = tx_er_q;
    assign busy_o       = (state_q != S_IDLE);
    assign frame_done_o = done_q;
    assign underrun_o   = ur_q;

endmodule
`default_nettype wire

// File: tb/tb_eth_tx_framer.sv
`default_nettype none
// =============================================================================
// Module   : tb_eth_tx_framer
// Brief    : Directed self-checking bench for eth_tx_framer (both FCS builds).
// Revision : 1.0
// =============================================================================
module tb_eth_tx_framer;

`ifdef ETH_TX_FCS_EN
    localparam int MINA = 60;
`else
    localparam int MINA = 64;
`endif

    logic       clk_i   = 1'b0;
    logic       reset_i = 1'b0;

    logic [8:0] a_rdd, b_rdd;
    logic       a_empty, b_empty;
    logic       a_pop, b_pop;
    logic [7:0] a_txd, b_txd;
    logic       a_en, a_er, a_busy, a_done, a_ur;
    logic       b_en, b_er, b_busy, b_done, b_ur;

    always #5 clk_i = ~clk_i;

    eth_tx_framer #(.IFG_CYCLES(12), .MIN_PAYLOAD(MINA)) u_dut_a (
        .clk_i(clk_i), .reset_i(reset_i),
        .fifo_rdd_i(a_rdd), .fifo_empty_i(a_empty), .fifo_pop_o(a_pop),
        .txd_o(a_txd), .tx_en_o(a_en), .tx_er_o(a_er), .busy_o(a_busy),
        .frame_done_o(a_done), .underrun_o(a_ur)
    );

    eth_tx_framer #(.IFG_CYCLES(12), .MIN_PAYLOAD(0)) u_dut_b (
        .clk_i(clk_i), .reset_i(reset_i),
        .fifo_rdd_i(b_rdd), .fifo_empty_i(b_empty), .fifo_pop_o(b_pop),
        .txd_o(b_txd), .tx_en_o(b_en), .tx_er_o(b_er), .busy_o(b_busy),
        .frame_done_o(b_done), .underrun_o(b_ur)
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Show-ahead FIFO models
    logic [8:0] qa[$];
    logic [8:0] qb[$];
    int a_npop = 0;

    task automatic a_upd();
        a_empty = (qa.size() == 0);
        a_rdd   = a_empty ? 9'h000 : qa[0];
    endtask

    task automatic b_upd();
        b_empty = (qb.size() == 0);
        b_rdd   = b_empty ? 9'h000 : qb[0];
    endtask

    always @(posedge clk_i) begin
        if (a_pop && qa.size() > 0) begin
            #1;
            void'(qa.pop_front());
            a_npop++;
            a_upd();
        end
    end

    always @(posedge clk_i) begin
        if (b_pop && qb.size() > 0) begin
            #1;
            void'(qb.pop_front());
            b_upd();
        end
    end

    // Output monitors, sampled on the falling edge
    int cyc = 0;
    logic [7:0] a_bytes[$];
    logic [7:0] b_bytes[$];
    int a_en_cnt, a_er_cnt, a_ur_cnt, a_urer_bad, a_done_cnt;
    int a_first_en, a_first_pop, a_zero, a_gap_last;
    bit a_seen;
    int b_en_cnt, b_done_cnt;

    task automatic clear_a();
        a_bytes.delete();
        a_en_cnt = 0; a_er_cnt = 0; a_ur_cnt = 0; a_urer_bad = 0; a_done_cnt = 0;
        a_first_en = -1; a_first_pop = -1; a_zero = 0; a_gap_last = 0; a_seen = 1'b0;
        a_npop = 0;
    endtask

    always @(negedge clk_i) begin
        cyc++;
        if (a_en) begin
            a_en_cnt++;
            if (!a_er) a_bytes.push_back(a_txd);
            if (a_first_en < 0) a_first_en = cyc;
            if (a_seen && a_zero > 0) a_gap_last = a_zero;
            a_zero = 0;
            a_seen = 1'b1;
        end else if (a_seen) begin
            a_zero++;
        end
        if (a_er) a_er_cnt++;
        if (a_ur) a_ur_cnt++;
        if (a_ur != a_er) a_urer_bad++;
        if (a_done) a_done_cnt++;
        if (a_pop && a_first_pop < 0) a_first_pop = cyc;
        if (b_en) begin
            b_en_cnt++;
            b_bytes.push_back(b_txd);
        end
        if (b_done) b_done_cnt++;
    end

    function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h000000, d};
        for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    logic [7:0] exp_a[$];

    task automatic push_pre_a();
        for (int i = 0; i < 7; i++) exp_a.push_back(8'h55);
        exp_a.push_back(8'hD5);
    endtask

    // Queue payload bytes [first,last) of an n-byte frame and record them as expected.
    task automatic push_range_a(input int first, input int last, input int n, input int seed);
        logic [7:0] b;
        for (int i = first; i < last; i++) begin
            b = 8'(seed + i * 7);
            qa.push_back({(i == n - 1), b});
            exp_a.push_back(b);
        end
        a_upd();
    endtask

    task automatic push_frame_a(input int n, input int seed);
        logic [31:0] crc;
        int base;
        crc = 32'hFFFFFFFF;
        push_pre_a();
        base = exp_a.size();
        push_range_a(0, n, n, seed);
        for (int i = n; i < MINA; i++) exp_a.push_back(8'h00);
        for (int i = base; i < exp_a.size(); i++) crc = crc_upd(crc, exp_a[i]);
`ifdef ETH_TX_FCS_EN
        for (int i = 0; i < 4; i++) exp_a.push_back(~crc[8*i +: 8]);
`endif
    endtask

    task automatic cmp_q(input string tag, input logic [7:0] got[$], input logic [7:0] exp[$]);
        int bad;
        bad = 0;
        check({tag, "_len"}, 32'(got.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < got.size(); i++) if (got[i] !== exp[i]) bad++;
        check({tag, "_bytes_wrong"}, 32'(bad), 32'd0);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        repeat (4) @(negedge clk_i);
        while (!(a_busy == 1'b0 && b_busy == 1'b0 && qa.size() == 0 && qb.size() == 0)
               && n < 4000) begin
            @(negedge clk_i);
            n++;
        end
        check({tag, "_in_time"}, 32'(n < 4000), 32'd1);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_txd"},   32'(a_txd),  32'h0);
        check({tag, "_en"},    32'(a_en),   32'h0);
        check({tag, "_er"},    32'(a_er),   32'h0);
        check({tag, "_pop"},   32'(a_pop),  32'h0);
        check({tag, "_busy"},  32'(a_busy), 32'h0);
        check({tag, "_done"},  32'(a_done), 32'h0);
        check({tag, "_ur"},    32'(a_ur),   32'h0);
    endtask

    int t0;
    int n;
    logic [7:0] exp_b[$];
    logic [7:0] c_crc_check[4];

    initial begin
        c_crc_check = '{8'h26, 8'h39, 8'hF4, 8'hCB};
        clear_a();
        b_en_cnt = 0; b_done_cnt = 0;
        a_upd();
        b_upd();

        // Reset state
        repeat (3) @(negedge clk_i);
        check_outputs_zero("reset");
        reset_i = 1'b1;
        repeat (3) @(negedge clk_i);

        // 1-byte frame: latency, padding, total enable length
        clear_a(); exp_a.delete();
        @(posedge clk_i); #2;
        t0 = cyc;
        push_frame_a(1, 8'hAB);
        wait_idle("one");
        check("one_first_en_lat",  32'(a_first_en - t0),  32'd3);
        check("one_first_pop_lat", 32'(a_first_pop - t0), 32'd10);
        cmp_q("one", a_bytes, exp_a);
        check("one_byte0", 32'(a_bytes.size() > 8 ? a_bytes[8] : 8'hxx), 32'h000000AB);
        check("one_en_cycles", 32'(a_en_cnt), 32'd72);
        check("one_done_pulses", 32'(a_done_cnt), 32'd1);
        check("one_er_cycles", 32'(a_er_cnt), 32'd0);

        // 64-byte frame: no padding
        clear_a(); exp_a.delete();
        @(posedge clk_i); #2;
        push_frame_a(64, 8'h21);
        wait_idle("f64");
        cmp_q("f64", a_bytes, exp_a);
`ifdef ETH_TX_FCS_EN
        check("f64_en_cycles", 32'(a_en_cnt), 32'd76);
`else
        check("f64_en_cycles", 32'(a_en_cnt), 32'd72);
`endif
        check("f64_done_pulses", 32'(a_done_cnt), 32'd1);

        // Back-to-back frames
        clear_a(); exp_a.delete();
        @(posedge clk_i); #2;
        push_frame_a(64, 8'h03);
        push_frame_a(64, 8'h05);
        wait_idle("b2b");
        cmp_q("b2b", a_bytes, exp_a);
`ifdef ETH_TX_FCS_EN
        check("b2b_en_cycles", 32'(a_en_cnt), 32'd152);
`else
        check("b2b_en_cycles", 32'(a_en_cnt), 32'd144);
`endif
        check("b2b_gap", 32'(a_gap_last), 32'd13);
        check("b2b_done_pulses", 32'(a_done_cnt), 32'd2);

        // Underrun after byte 40 of a 100-byte frame
        clear_a(); exp_a.delete();
        @(posedge clk_i); #2;
        push_pre_a();
        push_range_a(0, 40, 100, 8'h10);
        n = 0;
        while (a_ur_cnt == 0 && n < 500) begin @(negedge clk_i); n++; end
        check("ur_seen_in_time", 32'(n < 500), 32'd1);
        repeat (5) @(negedge clk_i);
        cmp_q("ur", a_bytes, exp_a);
        check("ur_er_cycles", 32'(a_er_cnt), 32'd1);
        check("ur_pulses", 32'(a_ur_cnt), 32'd1);
        check("ur_er_coincident", 32'(a_urer_bad), 32'd0);
        check("ur_en_cycles", 32'(a_en_cnt), 32'd49);
        @(posedge clk_i); #2;
        push_range_a(40, 100, 100, 8'h10);
        wait_idle("ur_drop");
        check("ur_popped", 32'(a_npop), 32'd100);
        check("ur_en_after_drop", 32'(a_en_cnt), 32'd49);
        check("ur_done_pulses", 32'(a_done_cnt), 32'd0);

        // Asynchronous reset during byte 20
        clear_a(); exp_a.delete();
        @(posedge clk_i); #2;
        push_frame_a(64, 8'h09);
        n = 0;
        while (a_bytes.size() < 28 && n < 500) begin @(negedge clk_i); n++; end
        check("rst_reach_byte20", 32'(n < 500), 32'd1);
        #2 reset_i = 1'b0;
        #1 check_outputs_zero("midrst");
        qa.delete();
        a_upd();
        repeat (2) @(negedge clk_i);
        reset_i = 1'b1;
        clear_a();
        repeat (30) @(negedge clk_i);
        check("post_rst_en_cycles", 32'(a_en_cnt), 32'd0);
        check("post_rst_busy", 32'(a_busy), 32'd0);

        // MIN_PAYLOAD = 0 instance: "123456789"
        b_bytes.delete(); b_en_cnt = 0; b_done_cnt = 0; exp_b.delete();
        for (int i = 0; i < 7; i++) exp_b.push_back(8'h55);
        exp_b.push_back(8'hD5);
        @(posedge clk_i); #2;
        for (int i = 0; i < 9; i++) begin
            qb.push_back({(i == 8), 8'(8'h31 + i)});
            exp_b.push_back(8'(8'h31 + i));
        end
`ifdef ETH_TX_FCS_EN
        for (int i = 0; i < 4; i++) exp_b.push_back(c_crc_check[i]);
`endif
        b_upd();
        wait_idle("chk9");
        cmp_q("chk9", b_bytes, exp_b);
        check("chk9_last_payload", 32'(b_bytes.size() > 16 ? b_bytes[16] : 8'hxx), 32'h39);
`ifdef ETH_TX_FCS_EN
        check("chk9_en_cycles", 32'(b_en_cnt), 32'd21);
`else
        check("chk9_en_cycles", 32'(b_en_cnt), 32'd17);
`endif
        check("chk9_done_pulses", 32'(b_done_cnt), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
